// File: rtl/adc_avg_feeder.sv
// Dual-channel ADC box-car averager feeding the PID (ch1) and CORDIC (ch2) operand capture.
// Optional OFFSET_CAL_EN adds per-channel offset subtraction with clamp-to-zero.
module adc_avg_chan #(
   parameter int DW       = 12,
   parameter int AVG_LOG2 = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             valid,
   input  logic [DW-1:0]    sample,
   input  logic [DW-1:0]    offset,
   output logic [DW-1:0]    data,
   output logic             strobe,
   output logic [CNT_W-1:0] win_cnt
);
   localparam int AW = DW + AVG_LOG2 + 1;
   localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, ACC, LOAD, STROBE} state_t;
   state_t state, state_nx;

   logic [AW-1:0]     acc, base_acc, sum;
   logic [AVG_LOG2:0] cnt, base_cnt;
   logic [DW-1:0]     smp;
   logic [DW:0]       avg_full;
   logic [DW-1:0]     avg;
   logic              in_load, take, done;

   // LOAD consumes the stored sum, so a sample landing there starts a fresh window
   always_comb begin
      smp      = (sample > offset) ? sample - offset : '0;
      in_load  = (state == LOAD);
      base_acc = in_load ? '0 : acc;
      base_cnt = in_load ? '0 : cnt;
      take     = valid && enable && (state != IDLE);
      done     = take && (base_cnt == LAST);
      sum      = base_acc + AW'(smp);
   end

   generate
      if (AVG_LOG2 == 0) begin : g_pass
         assign avg_full = acc;
      end else begin : g_round
         logic [AW-1:0] rnd;
         assign rnd      = acc + AW'(1 << (AVG_LOG2 - 1));
         assign avg_full = rnd[AW-1:AVG_LOG2];
      end
   endgenerate

   assign avg = avg_full[DW] ? {DW{1'b1}} : avg_full[DW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A window completing in LOAD/STROBE (short windows) re-enters LOAD so no sample is dropped
   always_comb begin
      state_nx = state;
      if (!enable) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    state_nx = ACC;
            ACC:     state_nx = done ? LOAD : ACC;
            LOAD:    state_nx = done ? LOAD : STROBE;
            STROBE:  state_nx = done ? LOAD : ACC;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         data    <= '0;
         strobe  <= 1'b0;
         win_cnt <= '0;
      end else begin
         if (in_load) data <= avg;
         strobe <= in_load;
         if (strobe) win_cnt <= win_cnt + 1'b1;
         if (!enable || state == IDLE) begin
            acc <= '0;
            cnt <= '0;
         end else if (take) begin
            acc <= sum;
            cnt <= done ? '0 : base_cnt + 1'b1;
         end else if (in_load) begin
            acc <= '0;
            cnt <= '0;
         end
      end
   end
endmodule

module adc_avg_feeder #(
   parameter int DW       = 12,
   parameter int AVG_LOG2 = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             adc_valid1,
   input  logic [DW-1:0]    adc_data1,
   input  logic             adc_valid2,
   input  logic [DW-1:0]    adc_data2,
`ifdef OFFSET_CAL_EN
   input  logic [DW-1:0]    offset1,
   input  logic [DW-1:0]    offset2,
`endif
   output logic [DW-1:0]    data_pid,
   output logic             write_enablepid,
   output logic [DW-1:0]    data_cordic,
   output logic             write_enablecordic,
   output logic [CNT_W-1:0] win_cnt1,
   output logic [CNT_W-1:0] win_cnt2
);
   logic [DW-1:0] off1, off2;
`ifdef OFFSET_CAL_EN
   assign off1 = offset1;
   assign off2 = offset2;
`else
   assign off1 = '0;
   assign off2 = '0;
`endif

   adc_avg_chan #(.DW(DW), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) u_ch1 (
      .clk(clk), .rst(rst), .enable(enable), .valid(adc_valid1), .sample(adc_data1),
      .offset(off1), .data(data_pid), .strobe(write_enablepid), .win_cnt(win_cnt1)
   );

   adc_avg_chan #(.DW(DW), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) u_ch2 (
      .clk(clk), .rst(rst), .enable(enable), .valid(adc_valid2), .sample(adc_data2),
      .offset(off2), .data(data_cordic), .strobe(write_enablecordic), .win_cnt(win_cnt2)
   );
endmodule
